// File: rtl/jzjpcc_memory_arbiter.sv
// Single-port memory backend arbiter between instruction fetch and the memory stage.
// Optional starvation guard: define JZJPCC_ARBITER_STARVATION_GUARD_EN.
module jzjpcc_memory_arbiter #(
    parameter int ADDR_WIDTH   = 30,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddr,
    output logic                  fetchGrant,
    output logic                  fetchStall,
    output logic                  fetchDataValid,
    output logic [31:0]           fetchData,

    input  logic                  dataReq,
    input  logic                  dataWriteEnable,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [31:0]           dataWriteData,
    input  logic [3:0]            dataByteMask,
    output logic                  dataGrant,
    output logic                  dataStall,
    output logic                  dataReadValid,
    output logic [31:0]           dataReadData,

    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memWriteEnable,
    output logic [31:0]           memDataToWrite,
    output logic [3:0]            memByteMask,
    input  logic [31:0]           memDataRead
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_FETCH = 2'd1;
    localparam logic [1:0] RD_DATA  = 2'd2;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       force_fetch;
    logic       data_grant;
    logic       fetch_grant;

`ifdef JZJPCC_ARBITER_STARVATION_GUARD_EN
    localparam int              COUNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(STARVE_LIMIT);

    logic [COUNT_WIDTH-1:0] starve_reg;
    logic [COUNT_WIDTH-1:0] starve_next;

    assign force_fetch = fetchReq && (starve_reg == LIMIT);

    // Counts data grants that fetch sat through; any fetch grant or idle fetch resets it.
    always_comb begin
        starve_next = starve_reg;
        if (!fetchReq || fetch_grant) begin
            starve_next = '0;
        end else if (data_grant && (starve_reg != LIMIT)) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end
`else
    // Without the guard the limit has no effect; this only keeps the parameter referenced.
    assign force_fetch = (STARVE_LIMIT < 0);
`endif

    // Grants are forced off while reset is held so no write can slip through.
    assign data_grant  = reset && dataReq && !force_fetch;
    assign fetch_grant = reset && fetchReq && !data_grant;

    assign fetchGrant = fetch_grant;
    assign dataGrant  = data_grant;
    assign fetchStall = fetchReq && !fetch_grant;
    assign dataStall  = dataReq && !data_grant;

    always_comb begin
        memAddress     = fetchAddr;
        memWriteEnable = 1'b0;
        memDataToWrite = dataWriteData;
        memByteMask    = 4'b0000;
        if (data_grant) begin
            memAddress     = dataAddr;
            memWriteEnable = dataWriteEnable;
            memByteMask    = dataByteMask;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (fetch_grant) begin
            state_next = RD_FETCH;
        end else if (data_grant && !dataWriteEnable) begin
            state_next = RD_DATA;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign fetchDataValid = (state_reg == RD_FETCH);
    assign dataReadValid  = (state_reg == RD_DATA);
    assign fetchData      = memDataRead;
    assign dataReadData   = memDataRead;

endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
// Bench for jzjpcc_memory_arbiter: per-cycle comparison against a request-level model,
// plus directed scenarios with hand-computed expectations.
module tb_jzjpcc_memory_arbiter;

    localparam int AW    = 30;
    localparam int LIMIT = 4;
`ifdef JZJPCC_ARBITER_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          fetchReq = 1'b0;
    logic [AW-1:0] fetchAddr = '0;
    logic          fetchGrant, fetchStall, fetchDataValid;
    logic [31:0]   fetchData;
    logic          dataReq = 1'b0;
    logic          dataWriteEnable = 1'b0;
    logic [AW-1:0] dataAddr = '0;
    logic [31:0]   dataWriteData = '0;
    logic [3:0]    dataByteMask = '0;
    logic          dataGrant, dataStall, dataReadValid;
    logic [31:0]   dataReadData;
    logic [AW-1:0] memAddress;
    logic          memWriteEnable;
    logic [31:0]   memDataToWrite;
    logic [3:0]    memByteMask;
    logic [31:0]   memDataRead = '0;

    int checks = 0;
    int errors = 0;

    jzjpcc_memory_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGrant(fetchGrant),
        .fetchStall(fetchStall), .fetchDataValid(fetchDataValid), .fetchData(fetchData),
        .dataReq(dataReq), .dataWriteEnable(dataWriteEnable), .dataAddr(dataAddr),
        .dataWriteData(dataWriteData), .dataByteMask(dataByteMask), .dataGrant(dataGrant),
        .dataStall(dataStall), .dataReadValid(dataReadValid), .dataReadData(dataReadData),
        .memAddress(memAddress), .memWriteEnable(memWriteEnable),
        .memDataToWrite(memDataToWrite), .memByteMask(memByteMask), .memDataRead(memDataRead)
    );

    always #5 clock = ~clock;

    // Backend: fixed content per address, registered read.
    function automatic logic [31:0] backend_word(input logic [AW-1:0] a);
        if (a == 30'h10) return 32'hDEADBEEF;
        return {a, 2'b00} ^ 32'hA5A50000;
    endfunction

    always @(posedge clock) memDataRead <= backend_word(memAddress);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who has waited how long, and which read (if any) is in flight.
    int            starve = 0;
    int            pending = 0;   // 0 none, 1 fetch read, 2 data read
    logic [AW-1:0] pend_addr = '0;
    bit            checking = 1'b1;

    function automatic void decide(output bit dg, output bit fg);
        bit fetch_overdue;
        fetch_overdue = GUARD && (fetchReq === 1'b1) && (starve >= LIMIT);
        dg = (reset === 1'b1) && (dataReq === 1'b1) && !fetch_overdue;
        fg = (reset === 1'b1) && (fetchReq === 1'b1) && !dg;
    endfunction

    always @(posedge clock or negedge reset) begin
        bit dg, fg;
        if (!reset) begin
            pending = 0;
            starve  = 0;
        end else begin
            decide(dg, fg);
            if (fg) begin
                pending = 1; pend_addr = fetchAddr;
            end else if (dg && !dataWriteEnable) begin
                pending = 2; pend_addr = dataAddr;
            end else begin
                pending = 0;
            end
            if (!fetchReq || fg) starve = 0;
            else if (dg && starve < LIMIT) starve = starve + 1;
        end
    end

    always @(negedge clock) begin
        bit dg, fg;
        if (checking) begin
            decide(dg, fg);
            chk("fetchGrant", 32'(fetchGrant), 32'(fg));
            chk("dataGrant", 32'(dataGrant), 32'(dg));
            chk("fetchStall", 32'(fetchStall), 32'(fetchReq & ~fg));
            chk("dataStall", 32'(dataStall), 32'(dataReq & ~dg));
            chk("memWriteEnable", 32'(memWriteEnable), 32'(dg & dataWriteEnable));
            if (dg) begin
                chk("memAddress(data)", 32'(memAddress), 32'(dataAddr));
                chk("memByteMask(data)", 32'(memByteMask), 32'(dataByteMask));
                if (dataWriteEnable) chk("memDataToWrite", memDataToWrite, dataWriteData);
            end
            if (fg) begin
                chk("memAddress(fetch)", 32'(memAddress), 32'(fetchAddr));
                chk("memByteMask(fetch)", 32'(memByteMask), 32'd0);
            end
            chk("fetchDataValid", 32'(fetchDataValid), 32'(pending == 1));
            chk("dataReadValid", 32'(dataReadValid), 32'(pending == 2));
            if (pending == 1) chk("fetchData", fetchData, backend_word(pend_addr));
            if (pending == 2) chk("dataReadData", dataReadData, backend_word(pend_addr));
        end
    end

    // One cycle of stimulus; returns mid-cycle so the caller can inspect outputs.
    task automatic drive(input logic rst, input logic fr, input logic [AW-1:0] fa,
                         input logic dr, input logic we, input logic [AW-1:0] da,
                         input logic [31:0] wd, input logic [3:0] bm);
        @(posedge clock);
        #1;
        reset = rst; fetchReq = fr; fetchAddr = fa;
        dataReq = dr; dataWriteEnable = we; dataAddr = da;
        dataWriteData = wd; dataByteMask = bm;
        @(negedge clock);
        #1;
        $display("cycle t=%0t rst=%b fr=%b fa=%h dr=%b we=%b da=%h -> fg=%b dg=%b addr=%h fv=%b dv=%b",
                 $time, rst, fr, fa, dr, we, da, fetchGrant, dataGrant, memAddress,
                 fetchDataValid, dataReadValid);
    endtask

    task automatic idle(input logic rst);
        drive(rst, 1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
    endtask

    logic [5:0] grants6;
    logic [4:0] grants5;

    initial begin
        // Reset held with both requests pending (one a write)
        drive(1'b0, 1'b1, 30'h10, 1'b1, 1'b1, 30'h20, 32'h1, 4'hF);
        chk("rst fetchGrant", 32'(fetchGrant), 32'd0);
        chk("rst dataGrant", 32'(dataGrant), 32'd0);
        chk("rst memWriteEnable", 32'(memWriteEnable), 32'd0);
        chk("rst valids", 32'({fetchDataValid, dataReadValid}), 32'd0);

        // Fetch only
        drive(1'b1, 1'b1, 30'h10, 1'b0, 1'b0, '0, 32'h0, 4'h0);
        chk("fo fetchGrant", 32'(fetchGrant), 32'd1);
        chk("fo memAddress", 32'(memAddress), 32'h10);
        idle(1'b1);
        chk("fo fetchDataValid", 32'(fetchDataValid), 32'd1);
        chk("fo fetchData", fetchData, 32'hDEADBEEF);
        chk("fo dataReadValid", 32'(dataReadValid), 32'd0);

        // Contention, then data drops
        drive(1'b1, 1'b1, 30'h30, 1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
        chk("ct dataGrant", 32'(dataGrant), 32'd1);
        chk("ct fetchStall", 32'(fetchStall), 32'd1);
        chk("ct memAddress", 32'(memAddress), 32'h20);
        drive(1'b1, 1'b1, 30'h30, 1'b0, 1'b0, 30'h20, 32'h0, 4'h0);
        chk("ct dataReadValid", 32'(dataReadValid), 32'd1);
        chk("ct dataReadData", dataReadData, 32'hA5A50080);
        chk("ct fetchGrant", 32'(fetchGrant), 32'd1);
        chk("ct memAddress2", 32'(memAddress), 32'h30);
        idle(1'b1);
        chk("ct fetchDataValid", 32'(fetchDataValid), 32'd1);
        chk("ct fetchData", fetchData, 32'hA5A500C0);

        // Write
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 30'h44, 32'h12345678, 4'b0011);
        chk("wr memWriteEnable", 32'(memWriteEnable), 32'd1);
        chk("wr memByteMask", 32'(memByteMask), 32'h3);
        chk("wr memDataToWrite", memDataToWrite, 32'h12345678);
        chk("wr memAddress", 32'(memAddress), 32'h44);
        idle(1'b1);
        chk("wr valids", 32'({fetchDataValid, dataReadValid}), 32'd0);

        // Starvation: both held six cycles
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 30'h50, 1'b1, 1'b0, 30'h60, 32'h0, 4'h0);
            grants6[i] = dataGrant;
        end
        chk("starve pattern", 32'(grants6), GUARD ? 32'b101111 : 32'b111111);

        // Fetch drops while stalled: no fetch response
        drive(1'b1, 1'b1, 30'h70, 1'b1, 1'b0, 30'h74, 32'h0, 4'h0);
        idle(1'b1);
        chk("drop fetchDataValid", 32'(fetchDataValid), 32'd0);
        idle(1'b1);

        // Reset mid-read
        drive(1'b1, 1'b1, 30'h10, 1'b0, 1'b0, '0, 32'h0, 4'h0);
        chk("mr fetchGrant", 32'(fetchGrant), 32'd1);
        drive(1'b0, 1'b1, 30'h10, 1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
        chk("mr fetchDataValid", 32'(fetchDataValid), 32'd0);
        chk("mr grants", 32'({fetchGrant, dataGrant}), 32'd0);
        idle(1'b0);
        idle(1'b1);
        chk("mr valids after", 32'({fetchDataValid, dataReadValid}), 32'd0);
        idle(1'b1);
        chk("mr valids after2", 32'({fetchDataValid, dataReadValid}), 32'd0);

        // Reset clears a partially-built starvation count
        drive(1'b1, 1'b1, 30'h50, 1'b1, 1'b0, 30'h60, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 30'h50, 1'b1, 1'b0, 30'h60, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 30'h50, 1'b1, 1'b0, 30'h60, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 30'h50, 1'b1, 1'b0, 30'h60, 32'h0, 4'h0);
            grants5[i] = dataGrant;
        end
        chk("reset clears count", 32'(grants5), GUARD ? 32'b01111 : 32'b11111);

        idle(1'b1);
        idle(1'b1);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jzjpcc_memory_arbiter.md
# jzjpcc_memory_arbiter

Shares the single-port, word-addressed memory backend between the instruction-fetch port and the data (memory-stage) port of the pipelined core. Each cycle it grants at most one requester and drives the backend address, write-enable, data and byte mask. Read data is routed back one cycle later with a per-port valid. Ungranted requesters receive a stall so the pipeline holds.

## Interface
- `ADDR_WIDTH`, default 30: word-address width (byte address bits [31:2]).
- `STARVE_LIMIT`, default 4: consecutive data grants, with fetch waiting, before fetch is forced (guard build only).

- `clock` in 1: core clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `fetchReq` in 1: fetch read request.
- `fetchAddr` in ADDR_WIDTH: fetch word address.
- `fetchGrant` out 1: fetch owns backend this cycle (combinational).
- `fetchStall` out 1: `fetchReq & ~fetchGrant`.
- `fetchDataValid` out 1: `fetchData` holds the word read for the previous fetch grant.
- `fetchData` out 32: wired to `memDataRead`.
- `dataReq` in 1: memory-stage access request.
- `dataWriteEnable` in 1: 1 = write, 0 = read.
- `dataAddr` in ADDR_WIDTH: data word address.
- `dataWriteData` in 32: write data.
- `dataByteMask` in 4: byte lanes to write.
- `dataGrant` out 1: data port owns backend this cycle.
- `dataStall` out 1: `dataReq & ~dataGrant`.
- `dataReadValid` out 1: `dataReadData` holds the word for the previous data read grant.
- `dataReadData` out 32: wired to `memDataRead`.
- `memAddress` out ADDR_WIDTH: backend address.
- `memWriteEnable` out 1: backend write strobe.
- `memDataToWrite` out 32: backend write data.
- `memByteMask` out 4: backend byte mask.
- `memDataRead` in 32: backend read data, valid one cycle after the address is presented.

## Operation
- Grant is combinational from the requests and the starvation state. Default priority: data over fetch.
- Granted port drives `memAddress`.
  - Data grant: the `mem*` write fields follow the data port; `memWriteEnable = dataWriteEnable`.
  - Fetch grant: `memWriteEnable = 0`, `memByteMask = 4'b0000`.
  - No grant: `memWriteEnable = 0`; address and data are don't-care (drive fetch values).
- Response FSM (registered) states:
  - IDLE: no read is returning.
  - RD_FETCH: a fetch read is returning.
  - RD_DATA: a data read is returning.
  - Next state each cycle: fetch grant → RD_FETCH; data read grant → RD_DATA; data write or no grant → IDLE.
  - `fetchDataValid = (state == RD_FETCH)`; `dataReadValid = (state == RD_DATA)`.
- Requesters must hold address, data and mask stable while stalled. The arbiter does not latch requests.
- Starvation counter (guard build), width `$clog2(STARVE_LIMIT+1)`:
  - Increments on a data grant while `fetchReq` = 1; saturates at STARVE_LIMIT.
  - Clears on a fetch grant or whenever `fetchReq` = 0.
  - When counter == STARVE_LIMIT and `fetchReq` = 1, fetch wins over data for that cycle.

## Timing
- Grant and stall: 0-cycle latency (same cycle as the request).
- Read latency: data/valid appear exactly 1 cycle after the grant. Back-to-back grants give one valid per cycle with no bubble.
- Write: committed at the granting edge; no response cycle.
- While `reset` = 0:
  - Grants = 0 and `memWriteEnable` = 0 (forced combinationally).
  - FSM = IDLE, so both valids = 0 immediately.
  - Counter = 0.
- Reset asserted mid-read: the returning word is discarded, with no valid after release.
- Both requests in the same cycle: exactly one grant; the other port stalls; never two grants.
- Request dropped while stalled: no grant and no response.

## Configuration
- `JZJPCC_ARBITER_STARVATION_GUARD_EN` defined: the starvation counter and forced fetch grant are present as described.
- Not defined: counter logic is removed and the STARVE_LIMIT parameter is ignored. Priority is strictly data over fetch, and fetch may stall indefinitely under continuous data requests.

## Test plan
- Fetch only: `fetchReq`=1, `fetchAddr`=0x10, backend returns 0xDEADBEEF → `fetchGrant`=1 and `memAddress`=0x10 in cycle 0; `fetchDataValid`=1 and `fetchData`=0xDEADBEEF in cycle 1; `dataReadValid`=0.
- Contention: both request reads, `dataAddr`=0x20, `fetchAddr`=0x30, both held → cycle 0: `dataGrant`=1, `fetchStall`=1, `memAddress`=0x20. Cycle 1: `dataReadValid`=1. After `dataReq` drops in cycle 1: `fetchGrant`=1, `memAddress`=0x30, and `fetchDataValid`=1 in cycle 2.
- Write: `dataReq`=1, `dataWriteEnable`=1, `dataByteMask`=4'b0011, `dataWriteData`=0x12345678 → `memWriteEnable`=1, `memByteMask`=0011, `memDataToWrite`=0x12345678 that cycle; both valids 0 next cycle.
- Starvation (guard build, STARVE_LIMIT=4): both requests held 6 cycles → data granted in cycles 0–3, fetch in cycle 4, data in cycle 5. Non-guard build → data granted in all 6 cycles.
- Reset mid-read: fetch granted in cycle 0, `reset` driven low in cycle 1 → `fetchDataValid`=0 and grants 0 while low. After release, with no requests, both valids stay 0 and the counter is 0.
